// File: rtl/testing_cpu_oci_dct_ctrl_if.sv
// testing_cpu_oci_dct_ctrl_if: trace-in, frame-out and status bundle of the OCI DCT sequencer.
// master = trace source / frame sink / monitor side, slave = sequencer side.
`default_nettype none

interface testing_cpu_oci_dct_ctrl_if #(
   parameter int SLOT_W = 2,
   parameter int SLOTS  = 15,
   parameter int CNT_W  = 4
);
   localparam int BUF_W = SLOT_W * SLOTS;

   logic              trc_valid;
   logic [SLOT_W-1:0] trc_code;
   logic              trc_ready;
   logic              flush;
   logic              test_ending;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              frm_valid;
   logic [BUF_W-1:0]  frm_data;
   logic [CNT_W-1:0]  frm_count;
   logic              frm_ready;
   logic              test_has_ended;

   modport master (
      output trc_valid, trc_code, flush, test_ending, frm_ready,
      input  trc_ready, dct_buffer, dct_count, frm_valid, frm_data, frm_count, test_has_ended
   );

   modport slave (
      input  trc_valid, trc_code, flush, test_ending, frm_ready,
      output trc_ready, dct_buffer, dct_count, frm_valid, frm_data, frm_count, test_has_ended
   );
endinterface

`default_nettype wire

// File: rtl/testing_cpu_oci_dct_ctrl.sv
// testing_cpu_oci_dct_ctrl: packs 2-bit trace codes into 15-slot frames and hands them to the
// trace sink over valid/ready; drains on test_ending. Rev 1.0
`default_nettype none

module testing_cpu_oci_dct_ctrl #(
   parameter int SLOT_W = 2,
   parameter int SLOTS  = 15,
   parameter int CNT_W  = 4
) (
   input wire                         clk,
   input wire                         reset_n,
   testing_cpu_oci_dct_ctrl_if.slave  bus
);
   localparam int               BUF_W   = SLOT_W * SLOTS;
   localparam logic [1:0]       ST_FILL = 2'd0;
   localparam logic [1:0]       ST_EMIT = 2'd1;
   localparam logic [1:0]       ST_DONE = 2'd2;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(SLOTS);

   logic [1:0]       state, state_nxt;
   logic [BUF_W-1:0] dct_buffer_q, dct_buffer_nxt;
   logic [CNT_W-1:0] dct_count_q, dct_count_nxt;
   logic             frm_valid_q, frm_valid_nxt;
   logic [BUF_W-1:0] frm_data_q, frm_data_nxt;
   logic [CNT_W-1:0] frm_count_q, frm_count_nxt;
   logic             end_pend_q, end_pend_nxt;
   logic [BUF_W-1:0] fill_buf;
   logic [CNT_W-1:0] fill_cnt;

   // reset_n is expected to arrive already release-synchronised to clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_FILL;
         dct_buffer_q <= '0;
         dct_count_q  <= '0;
         frm_valid_q  <= 1'b0;
         frm_data_q   <= '0;
         frm_count_q  <= '0;
         end_pend_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         dct_buffer_q <= dct_buffer_nxt;
         dct_count_q  <= dct_count_nxt;
         frm_valid_q  <= frm_valid_nxt;
         frm_data_q   <= frm_data_nxt;
         frm_count_q  <= frm_count_nxt;
         end_pend_q   <= end_pend_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      dct_buffer_nxt = dct_buffer_q;
      dct_count_nxt  = dct_count_q;
      frm_valid_nxt  = frm_valid_q;
      frm_data_nxt   = frm_data_q;
      frm_count_nxt  = frm_count_q;
      end_pend_nxt   = end_pend_q;
      fill_buf       = dct_buffer_q;
      fill_cnt       = dct_count_q;
      case (state)
         ST_FILL: begin
            // fill_buf/fill_cnt include this cycle's code so a frame closed now carries it
            if (bus.trc_valid) begin
               fill_buf[SLOT_W*int'(dct_count_q) +: SLOT_W] = bus.trc_code;
               fill_cnt = dct_count_q + CNT_W'(1);
            end
            if (bus.test_ending) end_pend_nxt = 1'b1;
            if (fill_cnt == FULL || ((bus.flush || bus.test_ending) && fill_cnt != '0)) begin
               state_nxt      = ST_EMIT;
               frm_valid_nxt  = 1'b1;
               frm_data_nxt   = fill_buf;
               frm_count_nxt  = fill_cnt;
               dct_buffer_nxt = '0;
               dct_count_nxt  = '0;
            end else begin
               dct_buffer_nxt = fill_buf;
               dct_count_nxt  = fill_cnt;
               if (bus.test_ending) state_nxt = ST_DONE;
            end
         end
         ST_EMIT: begin
            if (bus.test_ending) end_pend_nxt = 1'b1;
            if (bus.frm_ready) begin
               frm_valid_nxt = 1'b0;
               frm_data_nxt  = '0;
               frm_count_nxt = '0;
               state_nxt     = (end_pend_q || bus.test_ending) ? ST_DONE : ST_FILL;
            end
         end
         default: state_nxt = ST_DONE;
      endcase
   end

   always_comb begin
      bus.trc_ready      = (state == ST_FILL);
      bus.test_has_ended = (state == ST_DONE);
   end

   assign bus.dct_buffer = dct_buffer_q;
   assign bus.dct_count  = dct_count_q;
   assign bus.frm_valid  = frm_valid_q;
   assign bus.frm_data   = frm_data_q;
   assign bus.frm_count  = frm_count_q;

endmodule

`default_nettype wire

// File: tb/tb_testing_cpu_oci_dct_ctrl.sv
// tb_testing_cpu_oci_dct_ctrl: table-driven vectors plus hand sequences for the DCT sequencer.
`default_nettype none

module tb_testing_cpu_oci_dct_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   testing_cpu_oci_dct_ctrl_if bus ();

   testing_cpu_oci_dct_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  code;
      logic        fl;
      logic        te;
      logic        rdy;
      logic        e_trdy;
      logic        e_fv;
      logic [29:0] e_fd;
      logic [3:0]  e_fc;
      logic [3:0]  e_cnt;
      logic [29:0] e_buf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic trdy, input logic fv, input logic [29:0] fd,
                          input logic [3:0] fc, input logic [3:0] cnt, input logic [29:0] bf);
      chk({tag, " trc_ready"},  32'(bus.trc_ready),  32'(trdy));
      chk({tag, " frm_valid"},  32'(bus.frm_valid),  32'(fv));
      chk({tag, " frm_data"},   32'(bus.frm_data),   32'(fd));
      chk({tag, " frm_count"},  32'(bus.frm_count),  32'(fc));
      chk({tag, " dct_count"},  32'(bus.dct_count),  32'(cnt));
      chk({tag, " dct_buffer"}, 32'(bus.dct_buffer), 32'(bf));
   endtask

   task automatic step(input logic v, input logic [1:0] code, input logic fl, input logic te,
                       input logic rdy);
      @(negedge clk);
      bus.trc_valid   = v;
      bus.trc_code    = code;
      bus.flush       = fl;
      bus.test_ending = te;
      bus.frm_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.trc_valid   = 1'b0;
      bus.trc_code    = 2'b00;
      bus.flush       = 1'b0;
      bus.test_ending = 1'b0;
      bus.frm_ready   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic v, input logic [1:0] code, input logic fl, input logic te,
                               input logic rdy, input logic trdy, input logic fv,
                               input logic [29:0] fd, input logic [3:0] fc, input logic [3:0] cnt,
                               input logic [29:0] bf);
      vec_t r;
      r.v = v; r.code = code; r.fl = fl; r.te = te; r.rdy = rdy;
      r.e_trdy = trdy; r.e_fv = fv; r.e_fd = fd; r.e_fc = fc; r.e_cnt = cnt; r.e_buf = bf;
      return r;
   endfunction

   initial begin
      logic [29:0] ones;
      logic [29:0] mask;
      ones = 30'h15555555;

      // 15 accepts of code 01, sink always ready
      for (int i = 1; i <= 14; i++) begin
         mask = (30'd1 << (2 * i)) - 30'd1;
         vecs.push_back(mk(1, 2'b01, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'(i), ones & mask));
      end
      vecs.push_back(mk(1, 2'b01, 0, 0, 1, 0, 1, 30'h15555555, 4'hF, 4'h0, 30'h0));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h0, 30'h0));
      // codes 3,2,1 then flush
      vecs.push_back(mk(1, 2'b11, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h1, 30'h3));
      vecs.push_back(mk(1, 2'b10, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h2, 30'hB));
      vecs.push_back(mk(1, 2'b01, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h3, 30'h1B));
      vecs.push_back(mk(0, 2'b00, 1, 0, 1, 0, 1, 30'h1B, 4'h3, 4'h0, 30'h0));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h0, 30'h0));
      // accept together with flush on empty buffer; code offered during EMIT must wait
      vecs.push_back(mk(1, 2'b11, 1, 0, 0, 0, 1, 30'h3, 4'h1, 4'h0, 30'h0));
      vecs.push_back(mk(1, 2'b10, 1, 0, 0, 0, 1, 30'h3, 4'h1, 4'h0, 30'h0));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1, 0, 30'h0, 4'h0, 4'h0, 30'h0));
      // flush with nothing buffered
      vecs.push_back(mk(0, 2'b00, 1, 0, 1, 1, 0, 30'h0, 4'h0, 4'h0, 30'h0));

      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_all("reset", 1, 0, 30'h0, 4'h0, 4'h0, 30'h0);
      chk("reset test_has_ended", 32'(bus.test_has_ended), 32'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].code, vecs[i].fl, vecs[i].te, vecs[i].rdy);
         chk_all($sformatf("vec%0d", i), vecs[i].e_trdy, vecs[i].e_fv, vecs[i].e_fd,
                 vecs[i].e_fc, vecs[i].e_cnt, vecs[i].e_buf);
      end

      // full frame held under back-pressure
      for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 0, 0);
      chk_all("bp full", 0, 1, 30'h2AAAAAAA, 4'hF, 4'h0, 30'h0);
      for (int i = 0; i < 5; i++) begin
         step(1, 2'b01, 0, 0, 0);
         chk_all($sformatf("bp hold%0d", i), 0, 1, 30'h2AAAAAAA, 4'hF, 4'h0, 30'h0);
      end
      step(0, 2'b00, 0, 0, 1);
      chk_all("bp release", 1, 0, 30'h0, 4'h0, 4'h0, 30'h0);

      // repeated flush on empty buffer
      for (int i = 0; i < 10; i++) begin
         step(0, 2'b00, 1, 0, 1);
         chk($sformatf("empty flush%0d frm_valid", i), 32'(bus.frm_valid), 32'd0);
      end

      // asynchronous reset mid-frame
      step(1, 2'b11, 0, 0, 0);
      step(1, 2'b01, 0, 0, 0);
      chk("pre-rst dct_count", 32'(bus.dct_count), 32'd2);
      #3;
      idle_inputs();
      reset_n = 1'b0;
      #1;
      chk("async rst dct_count", 32'(bus.dct_count), 32'd0);
      chk("async rst dct_buffer", 32'(bus.dct_buffer), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // asynchronous reset mid-EMIT
      step(1, 2'b11, 1, 0, 0);
      chk("pre-rst frm_valid", 32'(bus.frm_valid), 32'd1);
      #3;
      idle_inputs();
      reset_n = 1'b0;
      #1;
      chk_all("async rst emit", 1, 0, 30'h0, 4'h0, 4'h0, 30'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 2'b00, 0, 0, 0);
      chk("post-rst trc_ready", 32'(bus.trc_ready), 32'd1);
      chk("post-rst test_has_ended", 32'(bus.test_has_ended), 32'd0);

      // codes 2,2 then test_ending: final frame then permanent DONE
      step(1, 2'b10, 0, 0, 0);
      step(1, 2'b10, 0, 0, 0);
      step(0, 2'b00, 0, 1, 0);
      chk_all("drain frame", 0, 1, 30'hA, 4'h2, 4'h0, 30'h0);
      step(0, 2'b00, 0, 0, 0);
      chk_all("drain hold", 0, 1, 30'hA, 4'h2, 4'h0, 30'h0);
      chk("drain hold test_has_ended", 32'(bus.test_has_ended), 32'd0);
      step(0, 2'b00, 0, 0, 1);
      chk_all("drain done", 0, 0, 30'h0, 4'h0, 4'h0, 30'h0);
      chk("drain test_has_ended", 32'(bus.test_has_ended), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1, 2'b11, 1, 1, 1);
         chk_all($sformatf("done%0d", i), 0, 0, 30'h0, 4'h0, 4'h0, 30'h0);
         chk($sformatf("done%0d test_has_ended", i), 32'(bus.test_has_ended), 32'd1);
      end

      // test_ending on an empty buffer goes straight to DONE
      do_reset();
      step(0, 2'b00, 0, 1, 0);
      chk_all("empty end", 0, 0, 30'h0, 4'h0, 4'h0, 30'h0);
      chk("empty end test_has_ended", 32'(bus.test_has_ended), 32'd1);

      // accept coinciding with test_ending is carried in the final frame
      do_reset();
      step(1, 2'b01, 0, 1, 0);
      chk_all("accept+end", 0, 1, 30'h1, 4'h1, 4'h0, 30'h0);
      step(0, 2'b00, 0, 0, 1);
      chk("accept+end test_has_ended", 32'(bus.test_has_ended), 32'd1);
      chk("accept+end frm_valid", 32'(bus.frm_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
